load_store_unit: RTL

- Sits between the execute/memory pipeline stage and the data memory.
- Accepts one load or store request at a time through a valid/ready handshake.
- For each request it checks alignment and funct3 legality, then drives a word-aligned memory access with byte strobes and replicated store data.
- It waits for the memory acknowledge with a timeout, then returns sign- or zero-extended load data or a fault code to the pipeline.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory access with byte strobes,
// bounded wait for mem_ack, then a single-cycle extended-load or fault response.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILL   = 2'b10;
    localparam logic [1:0] FAULT_TOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               lat_we, lat_we_d;
    logic [1:0]         lat_off, lat_off_d;
    logic [2:0]         lat_f3, lat_f3_d;

    logic               req_ready_d, resp_valid_d, mem_en_d, mem_we_d;
    logic [31:0]        resp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [1:0]         resp_fault_d;
    logic [3:0]         mem_wstrb_d;

    logic               illegal, misaligned, timeout_hit;
    logic [31:0]        st_wdata, ld_data;
    logic [3:0]         st_wstrb;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Request classification straight from the pipeline inputs
    always_comb begin
        if (req_we) begin
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack;
    end

    // Store lane replication and byte enables
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_off    <= 2'd0;
            lat_f3     <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= FAULT_OK;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_d;
            lat_we     <= lat_we_d;
            lat_off    <= lat_off_d;
            lat_f3     <= lat_f3_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_fault <= resp_fault_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wstrb  <= mem_wstrb_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (illegal || misaligned) ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; memory outputs read zero outside ACCESS
    always_comb begin
        req_ready_d  = (state_next == IDLE);
        resp_valid_d = (state_next == RESP);
        resp_rdata_d = '0;
        resp_fault_d = FAULT_OK;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wstrb_d  = '0;
        mem_wdata_d  = '0;
        cnt_d        = '0;
        lat_we_d     = lat_we;
        lat_off_d    = lat_off;
        lat_f3_d     = lat_f3;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d  = req_we;
                    lat_off_d = req_addr[1:0];
                    lat_f3_d  = req_funct3;
                    if (illegal) begin
                        resp_fault_d = FAULT_ILL;
                    end else if (misaligned) begin
                        resp_fault_d = FAULT_ALIGN;
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_we ? st_wstrb : 4'b0000;
                        mem_wdata_d = req_we ? st_wdata : 32'd0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    resp_rdata_d = lat_we ? 32'd0 : ld_data;
                end else if (timeout_hit) begin
                    resp_fault_d = FAULT_TOUT;
                end else begin
                    cnt_d       = cnt + CNT_W'(1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = mem_we;
                    mem_addr_d  = mem_addr;
                    mem_wstrb_d = mem_wstrb;
                    mem_wdata_d = mem_wdata;
                end
            end
            default: ;
        endcase
    end

endmodule
